icache_refill_ctrl: RTL and testbench
=====================================

# icache_refill_ctrl

Miss-handling sequencer for the 2-way instruction L1 (14-bit word address, 8-word lines, 32 sets).
- It sits between the fetch unit, the L1 array and the backing memory.
- Hits are forwarded combinationally.
- On a miss it stalls fetch, bursts the 8-word line from memory and writes it into the L1 in word order 0..7; word 7 finalises the line and flips its LRU bit. It then replays the lookup.
- It also keeps saturating hit/miss counters for performance monitoring.

## Interface
- ADDR_W, 14, word-address width
- WORDS, 8, words per line (offset width = log2(WORDS))
- CNT_W, 16, perf counter width
- clk  in  1  clock; all state updates on posedge (L1 array writes on negedge)
- reset  in  1  reset, synchronous, active-high
- cpu_req  in  1  fetch request; cpu_addr must stay stable while cpu_req=1 and cpu_ready=0
- cpu_addr  in  ADDR_W  fetch word address
- cpu_ready  out  1  fetch data valid this cycle
- cpu_rdata  out  32  fetched instruction word
- c_addr  out  ADDR_W  L1 address
- c_we  out  1  L1 write enable
- c_data  out  32  L1 write data
- c_dout  in  32  L1 read data
- c_hit  in  1  L1 hit for c_addr
- mem_req  out  1  line read request, held until granted
- mem_addr  out  ADDR_W  line base address (offset bits zero)
- mem_gnt  in  1  memory accepts the request
- mem_rvalid  in  1  one data beat valid; beats arrive in word order 0..7
- mem_rdata  in  32  beat data
- hit_cnt  out  CNT_W  lookups that hit (saturating)
- miss_cnt  out  CNT_W  refills started (saturating)

## Operation
- States: IDLE, REQ, FILL.
- **IDLE**
  - c_addr=cpu_addr; c_we=0; cpu_rdata=c_dout; cpu_ready=cpu_req&c_hit.
  - cpu_req&c_hit: hit_cnt++.
  - cpu_req&!c_hit: latch base={cpu_addr[ADDR_W-1:3],3'b0}, miss_cnt++, go to REQ.
- **REQ**
  - mem_req=1; mem_addr=base; cpu_ready=0.
  - mem_gnt=1: clear beat counter to 0, go to FILL.
  - mem_rvalid is ignored in REQ, including in the grant cycle.
- **FILL**
  - c_addr=base|beat; c_data=mem_rdata; c_we=mem_rvalid; cpu_ready=0.
  - Each rvalid cycle: beat++.
  - rvalid with beat==WORDS-1: go to IDLE.
  - Gaps (rvalid=0) are allowed and hold state.
- Refill always writes all 8 words with a constant tag/index. The way choice is left to the L1's LRU bit, and the final word flips it.
- Returning to IDLE replays the lookup on cpu_addr. That lookup now hits and counts in hit_cnt.
- If cpu_req drops mid-refill, the refill still completes. A new cpu_addr is only honoured in IDLE.
- mem_rvalid in IDLE is ignored.
- mem_req/mem_addr are 0 outside REQ. c_data=0 outside FILL.
- Counters saturate at 2^CNT_W-1 and never wrap.

## Timing
- Reset values:
  - state=IDLE, beat=0, base=0, hit_cnt=0, miss_cnt=0.
  - Outputs mem_req=0, mem_addr=0, c_we=0, c_data=0.
  - cpu_ready=0 unless cpu_req&c_hit in IDLE.
- Reset mid-REQ/FILL aborts immediately: state goes to IDLE and mem_req drops the next cycle. Any stray beats that follow are ignored. The L1 shares reset, so the partial line is invalidated.
- Hit latency: 0 cycles (combinational cpu_ready).
- Minimum miss latency, with miss in cycle 0 and gnt in cycle 1:
  - beats in cycles 2..9;
  - IDLE in cycle 10;
  - cpu_ready in cycle 10, so the penalty is 10 cycles.
- Each extra gnt wait or rvalid gap adds one cycle.
- c_we is asserted in the posedge-cycle of the beat; the L1 commits it at the following negedge, before the next posedge.

## Test plan
- Reset, then cpu_req=1 at 0x0040 on a cold cache -> cpu_ready=0, mem_req=1, mem_addr=0x0040, miss_cnt=1.
- Grant at cycle 1, beats 0xA0..0xA7 at cycles 2..9 -> c_we pulses 8 times with c_addr 0x0040..0x0047. At cycle 10, cpu_ready=1, cpu_rdata=0xA0, hit_cnt=1.
- Fetch 0x0045 after the refill -> cpu_ready same cycle with 0xA5; mem_req stays 0.
- Grant delayed 3 cycles, plus an rvalid gap after beat 3 -> ready at cycle 14; no writes during gaps; mem_rvalid asserted in the gnt cycle is not written.
- Assert reset during beat 4 of a refill -> IDLE next cycle, mem_req=0, counters=0. Refetching the same address misses again with miss_cnt=1.
- Force hit_cnt to 0xFFFF via 65535+ hits -> it holds at 0xFFFF on the next hit.

Source files
------------

// File: rtl/icache_refill_ctrl.sv
// icache_refill_ctrl: L1 I-cache miss sequencer; forwards hits, bursts 8-word lines from memory into the L1.
// Keeps saturating hit/miss counters for performance monitoring.
module icache_refill_ctrl #(
   parameter int ADDR_W = 14,
   parameter int WORDS  = 8,
   parameter int CNT_W  = 16,
   localparam int OFF_W = $clog2(WORDS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   output logic              cpu_ready,
   output logic [31:0]       cpu_rdata,
   output logic [ADDR_W-1:0] c_addr,
   output logic              c_we,
   output logic [31:0]       c_data,
   input  logic [31:0]       c_dout,
   input  logic              c_hit,
   output logic              mem_req,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic              mem_gnt,
   input  logic              mem_rvalid,
   input  logic [31:0]       mem_rdata,
   output logic [CNT_W-1:0]  hit_cnt,
   output logic [CNT_W-1:0]  miss_cnt
);
   typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;
   state_t             state_q, state_d;
   logic [OFF_W-1:0]   beat_q, beat_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [CNT_W-1:0]   hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         beat_q     <= '0;
         base_q     <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         beat_q     <= beat_d;
         base_q     <= base_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end
   always_comb begin
      state_d    = state_q;
      beat_d     = beat_q;
      base_d     = base_q;
      hit_cnt_d  = hit_cnt_q;
      miss_cnt_d = miss_cnt_q;
      c_addr     = cpu_addr;
      c_we       = 1'b0;
      c_data     = '0;
      cpu_rdata  = c_dout;
      cpu_ready  = 1'b0;
      mem_req    = 1'b0;
      mem_addr   = '0;
      case (state_q)
         IDLE: begin
            cpu_ready = cpu_req & c_hit;
            if (cpu_req && c_hit)
               hit_cnt_d = (hit_cnt_q == '1) ? hit_cnt_q : hit_cnt_q + CNT_W'(1);
            else if (cpu_req) begin
               base_d     = {cpu_addr[ADDR_W-1:OFF_W], OFF_W'(0)};
               miss_cnt_d = (miss_cnt_q == '1) ? miss_cnt_q : miss_cnt_q + CNT_W'(1);
               state_d    = REQ;
            end
         end
         REQ: begin
            mem_req  = 1'b1;
            mem_addr = base_q;
            if (mem_gnt) begin
               beat_d  = '0;
               state_d = FILL;
            end
         end
         FILL: begin
            // tag/index come from the latched base so the L1 sees one line throughout the burst
            c_addr = base_q | ADDR_W'(beat_q);
            c_data = mem_rdata;
            c_we   = mem_rvalid;
            if (mem_rvalid) begin
               beat_d  = beat_q + OFF_W'(1);
               state_d = (beat_q == OFF_W'(WORDS - 1)) ? IDLE : FILL;
            end
         end
         default: state_d = IDLE;
      endcase
   end
   assign hit_cnt  = hit_cnt_q;
   assign miss_cnt = miss_cnt_q;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// tb_icache_refill_ctrl: drives icache_refill_ctrl against a behavioural L1 and memory.
// L1 writes are scoreboarded; hit lookups come from a vector table.
module tb_icache_refill_ctrl;
   logic        clk = 0, reset = 1, cpu_req = 0, mem_gnt = 0, mem_rvalid = 0;
   logic [13:0] cpu_addr = '0;
   logic [31:0] mem_rdata = '0;
   logic        cpu_ready, c_we, c_hit, mem_req;
   logic [31:0] cpu_rdata, c_data, c_dout;
   logic [13:0] c_addr, mem_addr;
   logic [15:0] hit_cnt, miss_cnt;
   int          n_chk = 0, n_pass = 0, lat, exp_hit = 0;
   typedef struct {logic [13:0] a; logic [31:0] d;} wr_t;
   typedef struct {logic req; logic [13:0] a; logic rdy; logic [31:0] d;} vec_t;
   wr_t         sb[$];
   vec_t        tv[6];
   logic [31:0] l1_mem [0:16383];
   logic        l1_val [0:2047];

   icache_refill_ctrl dut (
      .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
      .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .c_addr(c_addr), .c_we(c_we),
      .c_data(c_data), .c_dout(c_dout), .c_hit(c_hit), .mem_req(mem_req),
      .mem_addr(mem_addr), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
      .mem_rdata(mem_rdata), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
   );

   always #5 clk = ~clk;

   assign c_hit  = l1_val[c_addr[13:3]] === 1'b1;
   assign c_dout = l1_mem[c_addr];

   // the L1 commits on negedge; the last word of a line makes it valid
   always @(negedge clk) begin
      if (reset) begin
         for (int i = 0; i < 2048; i++) l1_val[i] <= 1'b0;
      end else if (c_we) begin
         l1_mem[c_addr] <= c_data;
         if (c_addr[2:0] == 3'd7) l1_val[c_addr[13:3]] <= 1'b1;
      end
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", n, act, exp);
   endtask

   always @(negedge clk) begin
      if (!reset && c_we) begin
         if (sb.size() == 0) chk("unexpected_write_addr", {18'd0, c_addr}, 32'hFFFF_FFFF);
         else begin
            wr_t e;
            e = sb.pop_front();
            chk("wr_addr", {18'd0, c_addr}, {18'd0, e.a});
            chk("wr_data", c_data, e.d);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // miss on addr, grant after gw idle cycles, optional one-cycle gap after beat index gap
   task automatic refill(input logic [13:0] addr, input int gw, input int gap, input logic [31:0] db,
                         input bit rvg, output int l);
      int beat = 0;
      bit granted = 0, gapped = 0;
      logic [13:0] base = {addr[13:3], 3'b0};
      l = -1;
      for (int c = 0; c < 40; c++) begin
         step();
         cpu_req = 1; cpu_addr = addr; mem_gnt = 0; mem_rvalid = 0; mem_rdata = $urandom;
         if (c > 0) begin
            if (!granted) begin
               if (c == gw + 1) begin mem_gnt = 1; mem_rvalid = rvg; granted = 1; end
            end else if (beat < 8) begin
               if (beat == gap + 1 && !gapped) gapped = 1;
               else begin
                  mem_rvalid = 1;
                  mem_rdata = db + 32'(beat);
                  sb.push_back('{base + 14'(beat), db + 32'(beat)});
                  beat++;
               end
            end
         end
         @(negedge clk);
         if (mem_gnt) begin
            chk("gnt_mem_req", {31'd0, mem_req}, 32'd1);
            chk("gnt_mem_addr", {18'd0, mem_addr}, {18'd0, base});
            chk("gnt_no_write", {31'd0, c_we}, 32'd0);
         end
         if (cpu_ready) begin l = c; break; end
      end
      if (l < 0) chk("refill_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      tv[0] = '{1'b1, 14'h0045, 1'b1, 32'hA5};
      tv[1] = '{1'b1, 14'h0040, 1'b1, 32'hA0};
      tv[2] = '{1'b1, 14'h0047, 1'b1, 32'hA7};
      tv[3] = '{1'b0, 14'h0041, 1'b0, 32'h0};
      tv[4] = '{1'b1, 14'h0043, 1'b1, 32'hA3};
      tv[5] = '{1'b0, 14'h0999, 1'b0, 32'h0};
      repeat (2) step();
      reset = 0;
      @(negedge clk);
      chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
      chk("rst_mem_addr", {18'd0, mem_addr}, 32'd0);
      chk("rst_c_we", {31'd0, c_we}, 32'd0);
      chk("rst_c_data", c_data, 32'd0);
      chk("rst_cpu_ready", {31'd0, cpu_ready}, 32'd0);
      chk("rst_hit_cnt", {16'd0, hit_cnt}, 32'd0);
      chk("rst_miss_cnt", {16'd0, miss_cnt}, 32'd0);
      // cold miss with minimum latency
      refill(14'h0040, 0, 99, 32'hA0, 0, lat);
      chk("min_latency", lat, 10);
      chk("replay_rdata", cpu_rdata, 32'hA0);
      exp_hit++;
      step();
      cpu_req = 0;
      @(negedge clk);
      chk("hit_cnt_after_refill", {16'd0, hit_cnt}, exp_hit);
      chk("miss_cnt_after_refill", {16'd0, miss_cnt}, 32'd1);
      for (int i = 0; i < 6; i++) begin
         step();
         cpu_req = tv[i].req; cpu_addr = tv[i].a;
         @(negedge clk);
         chk($sformatf("vec%0d_ready", i), {31'd0, cpu_ready}, {31'd0, tv[i].rdy});
         if (tv[i].rdy) chk($sformatf("vec%0d_rdata", i), cpu_rdata, tv[i].d);
         chk($sformatf("vec%0d_mem_req", i), {31'd0, mem_req}, 32'd0);
         if (tv[i].req && tv[i].rdy) exp_hit++;
      end
      step();
      cpu_req = 0;
      @(negedge clk);
      chk("hit_cnt_after_vectors", {16'd0, hit_cnt}, exp_hit);
      // delayed grant, rvalid in the grant cycle, gap after beat 3
      refill(14'h1234, 3, 3, 32'hC0, 1, lat);
      chk("slow_latency", lat, 14);
      chk("slow_rdata", cpu_rdata, 32'hC4);
      exp_hit++;
      step();
      cpu_req = 0;
      @(negedge clk);
      chk("miss_cnt_two", {16'd0, miss_cnt}, 32'd2);
      chk("hit_cnt_slow", {16'd0, hit_cnt}, exp_hit);
      // reset during beat 4 aborts the refill
      for (int c = 0; c < 9; c++) begin
         step();
         cpu_req = (c < 6); cpu_addr = 14'h0100; mem_gnt = (c == 1);
         mem_rvalid = (c >= 2); mem_rdata = 32'hD0 + 32'(c - 2);
         reset = (c == 6);
         if (c >= 2 && c <= 5) sb.push_back('{14'h0100 + 14'(c - 2), 32'hD0 + 32'(c - 2)});
         @(negedge clk);
         if (c >= 7) begin
            chk($sformatf("abort%0d_mem_req", c), {31'd0, mem_req}, 32'd0);
            chk($sformatf("abort%0d_c_we", c), {31'd0, c_we}, 32'd0);
            chk($sformatf("abort%0d_hit_cnt", c), {16'd0, hit_cnt}, 32'd0);
            chk($sformatf("abort%0d_miss_cnt", c), {16'd0, miss_cnt}, 32'd0);
         end
      end
      exp_hit = 0;
      refill(14'h0100, 0, 99, 32'hB0, 0, lat);
      chk("refetch_latency", lat, 10);
      chk("refetch_rdata", cpu_rdata, 32'hB0);
      exp_hit++;
      step();
      cpu_req = 1; cpu_addr = 14'h0105;
      @(negedge clk);
      chk("refetch_miss_cnt", {16'd0, miss_cnt}, 32'd1);
      chk("hit_b5", cpu_rdata, 32'hB5);
      // saturate the hit counter
      repeat (65535 - exp_hit) @(posedge clk);
      @(negedge clk);
      chk("hit_cnt_max", {16'd0, hit_cnt}, 32'hFFFF);
      @(posedge clk);
      @(negedge clk);
      chk("hit_cnt_saturated", {16'd0, hit_cnt}, 32'hFFFF);
      chk("sat_ready", {31'd0, cpu_ready}, 32'd1);
      chk("sat_miss_cnt", {16'd0, miss_cnt}, 32'd1);
      step();
      cpu_req = 0;
      @(negedge clk);
      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
